// File: rtl/data_sram_resp_pkg.sv
// Shared definitions for the data-SRAM responder.
//   stateT        : FSM state encoding (IDLE / BUSY / RESP)
//   LAT_MIN/MAX   : legal bounds of the LATENCY parameter
//   CNT_W         : width of the latency down-counter
//   inRange()     : true when a byte address falls inside the backing store
package data_sram_resp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } stateT;

    localparam int LAT_MIN = 1;
    localparam int LAT_MAX = 8;
    localparam int CNT_W   = 3;

    // An address is in range when every bit above the word index is clear.
    function automatic logic inRange(input logic [31:0] byteAddr, input int addrW);
        logic [31:0] upper;
        upper = byteAddr >> (addrW + 2);
        return (upper == 32'd0);
    endfunction

endpackage

// File: rtl/data_sram_resp_if.sv
// Request/response bundle between a load/store initiator and the SRAM responder.
//   req/wr/wstrb/addr/wdata : request, driven by the initiator
//   addr_ok                 : responder can accept this cycle
//   data_ok/rdata/err       : one-cycle response strobe with payload
// Handshake: a request is accepted in any cycle where req && addr_ok. The
// response arrives later as a single-cycle data_ok pulse; rdata and err are
// meaningful only while data_ok is 1 and are held at 0 otherwise. There is no
// back-pressure on the response: the initiator must take it when it appears.
interface data_sram_resp_if;
    logic        req;
    logic        wr;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, wr, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata, err
    );

    modport slave (
        input  req, wr, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata, err
    );
endinterface

// File: rtl/data_sram_resp_dmem_bank.sv
// Backing store for the data-SRAM responder: 2**ADDR_W x 32-bit words,
// single read/write port, per-byte write enable and a registered read.
//   clk   : clock
//   en    : port access this cycle (read always, write lanes per we)
//   we    : byte-lane write enables, bit i covers wdata[8i+7:8i]
//   idx   : word index
//   wdata : write data, lane-aligned
//   rdata : registered read data (old contents on a write access)
// Contents are deliberately not reset.
module dmem_bank #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              en,
    input  logic [3:0]        we,
    input  logic [ADDR_W-1:0] idx,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 4; i++) begin
                if (we[i]) begin
                    mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/data_sram_resp.sv
// Data-SRAM responder: accepts one load/store at a time, completes it
// LATENCY cycles after the accept cycle with a single-cycle data_ok.
//   clk      : clock, rising edge
//   rst      : asynchronous, active-low reset
//   bus      : request/response bundle (slave side)
//   dbgState : current FSM state, for observation
module data_sram_resp
    import data_sram_resp_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    data_sram_resp_if.slave        bus,
    output stateT                  dbgState
);

    if (LATENCY < LAT_MIN || LATENCY > LAT_MAX) begin : gBadLatency
        $error("data_sram_resp: LATENCY out of range");
    end

    stateT            state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cntDec;
    logic             wrQ;
    logic [3:0]       wstrbQ;
    logic [31:0]      addrQ;
    logic [31:0]      wdataQ;
    logic             errQ;
    logic             wrRespQ;

    logic             accept;
    logic             bankGo;
    logic             srcWr;
    logic [3:0]       srcWstrb;
    logic [31:0]      srcAddr;
    logic [31:0]      srcWdata;
    logic             srcInRange;
    logic [3:0]       bankWe;
    logic [31:0]      bankRdata;

    assign accept = bus.req && (state == IDLE);
    assign cntDec = cnt - CNT_W'(1);

    // The bank is accessed on the edge that enters RESP so its registered
    // read lands in the response cycle. With LATENCY=1 that edge is the
    // accept edge itself, so the live request feeds the bank; otherwise the
    // captured copy does. BUSY exits once the decremented counter reaches 0.
    // rst gates the access so nothing is written while reset is held.
    always_comb begin
        bankGo = 1'b0;
        if (rst) begin
            if (state == IDLE) begin
                bankGo = accept && (LATENCY == 1);
            end else if (state == BUSY) begin
                bankGo = (cntDec == '0);
            end
        end
    end

    always_comb begin
        srcWr    = wrQ;
        srcWstrb = wstrbQ;
        srcAddr  = addrQ;
        srcWdata = wdataQ;
        if (state == IDLE) begin
            srcWr    = bus.wr;
            srcWstrb = bus.wstrb;
            srcAddr  = bus.addr;
            srcWdata = bus.wdata;
        end
    end

    assign srcInRange = inRange(srcAddr, ADDR_W);
    assign bankWe     = (bankGo && srcWr && srcInRange) ? srcWstrb : 4'b0000;

    dmem_bank #(
        .ADDR_W (ADDR_W)
    ) uBank (
        .clk   (clk),
        .en    (bankGo && srcInRange),
        .we    (bankWe),
        .idx   (srcAddr[ADDR_W+1:2]),
        .wdata (srcWdata),
        .rdata (bankRdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            wrQ     <= 1'b0;
            wstrbQ  <= 4'b0000;
            addrQ   <= 32'd0;
            wdataQ  <= 32'd0;
            errQ    <= 1'b0;
            wrRespQ <= 1'b0;
        end else begin
            if (bankGo) begin
                errQ    <= !srcInRange;
                wrRespQ <= srcWr;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        wrQ    <= bus.wr;
                        wstrbQ <= bus.wstrb;
                        addrQ  <= bus.addr;
                        wdataQ <= bus.wdata;
                        cnt    <= CNT_W'(LATENCY - 1);
                        state  <= (LATENCY == 1) ? RESP : BUSY;
                    end
                end
                BUSY: begin
                    cnt <= cntDec;
                    if (cntDec == '0) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.addr_ok = (state == IDLE);
    assign bus.data_ok = (state == RESP);
    assign bus.err     = bus.data_ok && errQ;
    assign bus.rdata   = (bus.data_ok && !errQ && !wrRespQ) ? bankRdata : 32'd0;
    assign dbgState    = state;

endmodule

// File: tb/tb_data_sram_resp.sv
module tb_data_sram_resp;
    import data_sram_resp_pkg::*;

    logic  clk;
    logic  rst;
    stateT dbgState;
    int    passCnt;
    int    checkCnt;
    int    cyc;

    data_sram_resp_if bus();

    data_sram_resp #(
        .ADDR_W  (10),
        .LATENCY (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .dbgState (dbgState)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    // One transaction from IDLE. Inputs are scrambled right after the accept
    // to show the captured copy is what completes. lat counts cycles from the
    // accept cycle to the data_ok cycle; the task returns in the data_ok cycle.
    task automatic txn(input logic w, input logic [3:0] s, input logic [31:0] a,
                       input logic [31:0] d, output logic [31:0] rd,
                       output logic e, output int lat);
        @(negedge clk);
        bus.req = 1'b1; bus.wr = w; bus.wstrb = s; bus.addr = a; bus.wdata = d;
        @(negedge clk);
        bus.req = 1'b0; bus.wr = ~w; bus.wstrb = 4'hF;
        bus.addr = $urandom; bus.wdata = $urandom;
        lat = 1;
        #1;
        while (!bus.data_ok && lat < 20) begin
            @(negedge clk); #1; lat++;
        end
        rd = bus.rdata;
        e  = bus.err;
    endtask

    task automatic test_reset();
        bus.req = 1'b0; bus.wr = 1'b0; bus.wstrb = 4'h0; bus.addr = 32'd0; bus.wdata = 32'd0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checkCnt++; if (bus.addr_ok !== 1'b1) $display("FAIL reset_addr_ok: got %b expected 1", bus.addr_ok); else passCnt++;
        checkCnt++; if (bus.data_ok !== 1'b0) $display("FAIL reset_data_ok: got %b expected 0", bus.data_ok); else passCnt++;
        checkCnt++; if (bus.rdata !== 32'd0) $display("FAIL reset_rdata: got %h expected 0", bus.rdata); else passCnt++;
        checkCnt++; if (bus.err !== 1'b0) $display("FAIL reset_err: got %b expected 0", bus.err); else passCnt++;
        checkCnt++; if (dbgState !== IDLE) $display("FAIL reset_state: got %0d expected 0", dbgState); else passCnt++;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_latency();
        logic [31:0] rd; logic e; int lat; int n;
        n = 0;
        while (cyc < 9 && n < 50) begin @(negedge clk); n++; end
        // next negedge is cycle 10, the accept cycle
        txn(1'b0, 4'h0, 32'h0000_0010, 32'd0, rd, e, lat);
        checkCnt++; if (lat !== 2) $display("FAIL load_latency: got %0d expected 2", lat); else passCnt++;
        checkCnt++; if (cyc !== 12) $display("FAIL load_resp_cycle: got %0d expected 12", cyc); else passCnt++;
        checkCnt++; if (e !== 1'b0) $display("FAIL load_err: got %b expected 0", e); else passCnt++;
        @(negedge clk); #1;
        checkCnt++; if (bus.data_ok !== 1'b0) $display("FAIL data_ok_one_cycle: got %b expected 0", bus.data_ok); else passCnt++;
        checkCnt++; if (bus.rdata !== 32'd0) $display("FAIL rdata_idle_zero: got %h expected 0", bus.rdata); else passCnt++;
    endtask

    task automatic test_byte_strobe();
        logic [31:0] rd; logic e; int lat;
        txn(1'b1, 4'b1111, 32'h40, 32'hDEAD_BEEF, rd, e, lat);
        checkCnt++; if (rd !== 32'd0) $display("FAIL store_rdata: got %h expected 0", rd); else passCnt++;
        checkCnt++; if (lat !== 2) $display("FAIL store_latency: got %0d expected 2", lat); else passCnt++;
        txn(1'b1, 4'b0001, 32'h40, 32'h0000_00AA, rd, e, lat);
        txn(1'b0, 4'b0000, 32'h40, 32'd0, rd, e, lat);
        checkCnt++; if (rd !== 32'hDEAD_BEAA) $display("FAIL byte_merge: got %h expected deadbeaa", rd); else passCnt++;
    endtask

    task automatic test_zero_strobe();
        logic [31:0] rd; logic e; int lat;
        txn(1'b1, 4'b1111, 32'h44, 32'h1234_5678, rd, e, lat);
        txn(1'b1, 4'b0000, 32'h44, 32'hFFFF_FFFF, rd, e, lat);
        checkCnt++; if (lat !== 2) $display("FAIL zero_strb_data_ok: got latency %0d expected 2", lat); else passCnt++;
        txn(1'b0, 4'b0000, 32'h44, 32'd0, rd, e, lat);
        checkCnt++; if (rd !== 32'h1234_5678) $display("FAIL zero_strb_keep: got %h expected 12345678", rd); else passCnt++;
        // top word of the store
        txn(1'b1, 4'b1111, 32'hFFC, 32'hA5A5_5A5A, rd, e, lat);
        checkCnt++; if (e !== 1'b0) $display("FAIL top_word_err: got %b expected 0", e); else passCnt++;
        txn(1'b0, 4'b0000, 32'hFFE, 32'd0, rd, e, lat);
        checkCnt++; if (rd !== 32'hA5A5_5A5A) $display("FAIL top_word_read: got %h expected a5a55a5a", rd); else passCnt++;
    endtask

    task automatic test_out_of_range();
        logic [31:0] rd; logic e; int lat;
        txn(1'b1, 4'b1111, 32'h0, 32'h0BAD_F00D, rd, e, lat);
        txn(1'b0, 4'b0000, 32'h0000_1000, 32'd0, rd, e, lat);
        checkCnt++; if (e !== 1'b1) $display("FAIL oor_load_err: got %b expected 1", e); else passCnt++;
        checkCnt++; if (rd !== 32'd0) $display("FAIL oor_load_rdata: got %h expected 0", rd); else passCnt++;
        txn(1'b1, 4'b1111, 32'h0000_1000, 32'hCAFE_F00D, rd, e, lat);
        checkCnt++; if (e !== 1'b1) $display("FAIL oor_store_err: got %b expected 1", e); else passCnt++;
        // 0x1000 aliases word 0 if the range check is missing
        txn(1'b0, 4'b0000, 32'h0, 32'd0, rd, e, lat);
        checkCnt++; if (rd !== 32'h0BAD_F00D) $display("FAIL oor_word0: got %h expected 0badf00d", rd); else passCnt++;
        txn(1'b0, 4'b0000, 32'h40, 32'd0, rd, e, lat);
        checkCnt++; if (rd !== 32'hDEAD_BEAA) $display("FAIL oor_word40: got %h expected deadbeaa", rd); else passCnt++;
        txn(1'b0, 4'b0000, 32'h44, 32'd0, rd, e, lat);
        checkCnt++; if (rd !== 32'h1234_5678) $display("FAIL oor_word44: got %h expected 12345678", rd); else passCnt++;
    endtask

    task automatic test_back_to_back();
        logic [11:0] accepts;
        logic [11:0] addrOks;
        int dataOks;
        int badRd;
        @(negedge clk);
        bus.req = 1'b1; bus.wr = 1'b0; bus.wstrb = 4'h0; bus.addr = 32'h40; bus.wdata = 32'd0;
        dataOks = 0; badRd = 0;
        for (int i = 0; i < 12; i++) begin
            #1;
            accepts[i] = bus.req && bus.addr_ok;
            addrOks[i] = bus.addr_ok;
            if (bus.data_ok) begin
                dataOks++;
                if (bus.rdata !== 32'hDEAD_BEAA) badRd++;
            end
            @(negedge clk);
        end
        bus.req = 1'b0;
        checkCnt++; if (accepts !== 12'b0010_0100_1001) $display("FAIL b2b_accepts: got %b expected 001001001001", accepts); else passCnt++;
        checkCnt++; if (addrOks !== 12'b0010_0100_1001) $display("FAIL b2b_addr_ok: got %b expected 001001001001", addrOks); else passCnt++;
        checkCnt++; if (dataOks !== 4) $display("FAIL b2b_data_ok_count: got %0d expected 4", dataOks); else passCnt++;
        checkCnt++; if (badRd !== 0) $display("FAIL b2b_rdata: got %0d bad reads expected 0", badRd); else passCnt++;
    endtask

    task automatic test_reset_mid_store();
        logic [31:0] rd; logic e; int lat; int seen;
        txn(1'b1, 4'b1111, 32'h80, 32'h1111_2222, rd, e, lat);
        @(negedge clk);
        bus.req = 1'b1; bus.wr = 1'b1; bus.wstrb = 4'hF; bus.addr = 32'h80; bus.wdata = 32'hFFFF_FFFF;
        @(negedge clk);
        bus.req = 1'b0;
        #1;
        checkCnt++; if (dbgState !== BUSY) $display("FAIL rst_mid_busy: got %0d expected 1", dbgState); else passCnt++;
        #1 rst = 1'b0;
        #1;
        checkCnt++; if (bus.addr_ok !== 1'b1) $display("FAIL rst_mid_addr_ok: got %b expected 1", bus.addr_ok); else passCnt++;
        @(negedge clk);
        rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            #1; if (bus.data_ok) seen++;
            @(negedge clk);
        end
        checkCnt++; if (seen !== 0) $display("FAIL rst_mid_no_data_ok: got %0d pulses expected 0", seen); else passCnt++;
        txn(1'b0, 4'b0000, 32'h80, 32'd0, rd, e, lat);
        checkCnt++; if (rd !== 32'h1111_2222) $display("FAIL rst_mid_storage: got %h expected 11112222", rd); else passCnt++;
    endtask

    initial begin
        passCnt = 0;
        checkCnt = 0;
        test_reset();
        test_latency();
        test_byte_strobe();
        test_zero_strobe();
        test_out_of_range();
        test_back_to_back();
        test_reset_mid_store();
        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
